// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: load/store width codes,
// FSM state encodings, exception causes, write-back source codes, the
// captured-instruction and write-back payload structs, and the fault check.
package mem_stage_pkg;

    localparam int unsigned XLEN = 32;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // exc_cause codes
    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    // write-back source select codes
    localparam logic [1:0] FROM_ALU = 2'b00;
    localparam logic [1:0] FROM_MEM = 2'b01;
    localparam logic [1:0] FROM_PC4 = 2'b10;
    localparam logic [1:0] FROM_IMM = 2'b11;

    // Instruction fields held while a memory op is in flight
    typedef struct packed {
        logic            mem_read;
        logic [2:0]      funct3;
        logic [XLEN-1:0] alu_result;
        logic [1:0]      reg_src;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            reg_write;
    } op_t;

    // Everything write-back consumes
    typedef struct packed {
        logic [1:0]      reg_src;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] mem2reg_data;
        logic [4:0]      rd;
        logic            reg_write;
    } wb_t;

    // Build the write-back payload; allow_write gates the register write
    function automatic wb_t make_wb(input op_t op, input logic [XLEN-1:0] data,
                                    input logic allow_write);
        wb_t wb;
        wb.reg_src      = op.reg_src;
        wb.pc_plus4     = op.pc_plus4;
        wb.imm          = op.imm;
        wb.alu_result   = op.alu_result;
        wb.mem2reg_data = data;
        wb.rd           = op.rd;
        wb.reg_write    = op.reg_write & allow_write;
        return wb;
    endfunction

    // Fault check in priority order: illegal encodings before misalignment
    function automatic logic [1:0] check_exc(input logic is_load, input logic is_store,
                                             input logic [2:0] f3, input logic [1:0] addr_lo);
        if (is_load && is_store)
            return EXC_ILLEGAL;
        if (is_load && !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
            return EXC_ILLEGAL;
        if (is_store && !(f3 inside {F3_B, F3_H, F3_W}))
            return EXC_ILLEGAL;
        // f3[1:0] is the access size once the encoding is known legal
        if ((is_load || is_store) &&
            ((f3[1:0] == 2'b01 && addr_lo[0]) || (f3[1:0] == 2'b10 && addr_lo != 2'b00)))
            return EXC_MISALIGN;
        return EXC_NONE;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the byte/halfword addressed by addr_lo from
// the read word and sign- or zero-extends it according to funct3.
//   rdata   - word returned by memory
//   addr_lo - byte offset within the word
//   funct3  - load width code
//   data_c  - extended load value (0 for non-load codes)
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {addr_lo, 3'b000});
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_c = {{16{half_sel[15]}}, half_sel};
            F3_W:    data_c = rdata;
            F3_BU:   data_c = {24'd0, byte_sel};
            F3_HU:   data_c = {16'd0, half_sel};
            default: data_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage between execute and write-back. Accepts one
// instruction in IDLE, performs the load/store over a valid/ready data bus
// (REQ then RESP), and emits a one-cycle out_valid pulse with the registered
// write-back payload. Faults and response timeouts pulse mem_exc alongside.
//   in_*        - instruction from execute, accepted when in_valid & in_ready
//   dmem_req_*  - request channel (word address, we, byte enables, wdata)
//   dmem_resp_* - response channel, sampled only in RESP
//   out_*       - write-back payload, held between pulses
//   mem_exc / exc_cause - exception pulse and its cause
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned RESP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mem_read,
    input  logic            in_mem_write,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [1:0]      in_reg_src,
    input  logic [XLEN-1:0] in_pc_plus4,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    input  logic            in_reg_write,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            out_valid,
    output logic [1:0]      out_reg_src,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_alu_result,
    output logic [XLEN-1:0] out_mem2reg_data,
    output logic [4:0]      out_rd,
    output logic            out_reg_write,
    output logic            mem_exc,
    output logic [1:0]      exc_cause
);

    localparam int unsigned CNT_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    logic [1:0]       state_q, state_nxt;
    op_t              op_q, op_nxt, in_op;
    wb_t              wb_q, wb_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             req_valid_q, req_valid_nxt;
    logic [XLEN-1:0]  addr_q, addr_nxt;
    logic             we_q, we_nxt;
    logic [3:0]       be_q, be_nxt;
    logic [XLEN-1:0]  wdata_q, wdata_nxt;
    logic             out_valid_q, out_valid_nxt;
    logic             exc_q, exc_nxt;
    logic [1:0]       cause_q, cause_nxt;
    logic [1:0]       in_exc;
    logic             timeout_hit;
    logic [XLEN-1:0]  load_data;

    mem_stage_load_align u_load_align (
        .rdata   (dmem_rdata),
        .addr_lo (op_q.alu_result[1:0]),
        .funct3  (op_q.funct3),
        .data_c  (load_data)
    );

    // Incoming instruction as a capture payload, plus its fault check
    always_comb begin
        in_op.mem_read   = in_mem_read;
        in_op.funct3     = in_funct3;
        in_op.alu_result = in_alu_result;
        in_op.reg_src    = in_reg_src;
        in_op.pc_plus4   = in_pc_plus4;
        in_op.imm        = in_imm;
        in_op.rd         = in_rd;
        in_op.reg_write  = in_reg_write;
        in_exc = check_exc(in_mem_read, in_mem_write, in_funct3, in_alu_result[1:0]);
    end

    // The counter sits at N-1 during the Nth cycle spent in RESP
    assign timeout_hit = (RESP_TIMEOUT != 0) && (cnt_q == CNT_W'(RESP_TIMEOUT - 1));

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state_q;
        op_nxt        = op_q;
        wb_nxt        = wb_q;
        cnt_nxt       = cnt_q;
        req_valid_nxt = req_valid_q;
        addr_nxt      = addr_q;
        we_nxt        = we_q;
        be_nxt        = be_q;
        wdata_nxt     = wdata_q;
        out_valid_nxt = 1'b0;
        exc_nxt       = 1'b0;
        cause_nxt     = cause_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_exc != EXC_NONE) begin
                        out_valid_nxt = 1'b1;
                        exc_nxt       = 1'b1;
                        cause_nxt     = in_exc;
                        wb_nxt        = make_wb(in_op, '0, 1'b0);
                    end else if (in_mem_read || in_mem_write) begin
                        state_nxt     = ST_REQ;
                        op_nxt        = in_op;
                        req_valid_nxt = 1'b1;
                        addr_nxt      = {in_alu_result[XLEN-1:2], 2'b00};
                        we_nxt        = in_mem_write;
                        be_nxt        = 4'b0000;
                        wdata_nxt     = '0;
                        if (in_mem_write) begin
                            case (in_funct3)
                                F3_B: begin
                                    be_nxt    = 4'b0001 << in_alu_result[1:0];
                                    wdata_nxt = {4{in_rs2_data[7:0]}};
                                end
                                F3_H: begin
                                    be_nxt    = 4'b0011 << {in_alu_result[1], 1'b0};
                                    wdata_nxt = {2{in_rs2_data[15:0]}};
                                end
                                default: begin
                                    be_nxt    = 4'b1111;
                                    wdata_nxt = in_rs2_data;
                                end
                            endcase
                        end
                    end else begin
                        out_valid_nxt = 1'b1;
                        cause_nxt     = EXC_NONE;
                        wb_nxt        = make_wb(in_op, '0, 1'b1);
                    end
                end
            end
            ST_REQ: begin
                if (dmem_req_ready) begin
                    state_nxt     = ST_RESP;
                    req_valid_nxt = 1'b0;
                    cnt_nxt       = '0;
                end
            end
            ST_RESP: begin
                if (dmem_resp_valid) begin
                    state_nxt     = ST_IDLE;
                    out_valid_nxt = 1'b1;
                    cause_nxt     = EXC_NONE;
                    wb_nxt        = make_wb(op_q, op_q.mem_read ? load_data : '0, 1'b1);
                end else if (timeout_hit) begin
                    state_nxt     = ST_IDLE;
                    out_valid_nxt = 1'b1;
                    exc_nxt       = 1'b1;
                    cause_nxt     = EXC_TIMEOUT;
                    wb_nxt        = make_wb(op_q, '0, 1'b0);
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                req_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            wb_q        <= '0;
            cnt_q       <= '0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            out_valid_q <= 1'b0;
            exc_q       <= 1'b0;
            cause_q     <= EXC_NONE;
        end else begin
            state_q     <= state_nxt;
            op_q        <= op_nxt;
            wb_q        <= wb_nxt;
            cnt_q       <= cnt_nxt;
            req_valid_q <= req_valid_nxt;
            addr_q      <= addr_nxt;
            we_q        <= we_nxt;
            be_q        <= be_nxt;
            wdata_q     <= wdata_nxt;
            out_valid_q <= out_valid_nxt;
            exc_q       <= exc_nxt;
            cause_q     <= cause_nxt;
        end
    end

    assign in_ready         = (state_q == ST_IDLE);
    assign dmem_req_valid   = req_valid_q;
    assign dmem_addr        = addr_q;
    assign dmem_we          = we_q;
    assign dmem_be          = be_q;
    assign dmem_wdata       = wdata_q;
    assign out_valid        = out_valid_q;
    assign out_reg_src      = wb_q.reg_src;
    assign out_pc_plus4     = wb_q.pc_plus4;
    assign out_imm          = wb_q.imm;
    assign out_alu_result   = wb_q.alu_result;
    assign out_mem2reg_data = wb_q.mem2reg_data;
    assign out_rd           = wb_q.rd;
    assign out_reg_write    = wb_q.reg_write;
    assign mem_exc          = exc_q;
    assign exc_cause        = cause_q;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: directed scenarios plus randomized loads, stores,
// ALU ops and faulting ops, checked against a plain-arithmetic reference.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_alu_result = 32'd0;
    logic [31:0] in_rs2_data = 32'd0;
    logic [1:0]  in_reg_src = 2'd0;
    logic [31:0] in_pc_plus4 = 32'd0;
    logic [31:0] in_imm = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_reg_write = 1'b0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        out_valid;
    logic [1:0]  out_reg_src;
    logic [31:0] out_pc_plus4;
    logic [31:0] out_imm;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem2reg_data;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        mem_exc;
    logic [1:0]  exc_cause;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(.RESP_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_funct3(in_funct3), .in_alu_result(in_alu_result),
        .in_rs2_data(in_rs2_data), .in_reg_src(in_reg_src),
        .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_reg_src(out_reg_src),
        .out_pc_plus4(out_pc_plus4), .out_imm(out_imm),
        .out_alu_result(out_alu_result), .out_mem2reg_data(out_mem2reg_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .mem_exc(mem_exc), .exc_cause(exc_cause)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exception cause from the ISA rules
    function automatic logic [1:0] ref_exc(input bit rd_, input bit wr_,
                                           input logic [2:0] f3, input logic [31:0] a);
        bit load_ok  = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        bit store_ok = (f3 <= 2);
        int size     = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        if (rd_ && wr_) return 2'd2;
        if (rd_ && !load_ok) return 2'd2;
        if (wr_ && !store_ok) return 2'd2;
        if ((rd_ || wr_) && (a % size != 0)) return 2'd1;
        return 2'd0;
    endfunction

    // Reference: loaded value from the word, offset and width
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b = (w >> (8 * (a % 4))) & 32'hFF;
        logic [31:0] h = (w >> (8 * (a % 4))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd2:    return w;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 0) return 32'd1 << (a % 4);
        if (f3 == 1) return 32'd3 << (a % 4);
        return 32'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] v);
        if (f3 == 0) return (v & 32'hFF) * 32'h0101_0101;
        if (f3 == 1) return (v & 32'hFFFF) * 32'h0001_0001;
        return v;
    endfunction

    // One complete instruction through the stage, checked at every step
    task automatic run_op(input bit rd_, input bit wr_, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] pc4, input logic [31:0] imm,
                          input logic [31:0] rdata, input logic [1:0] rs,
                          input logic [4:0] rdst, input bit rw,
                          input int req_wait, input int resp_wait, input bit stray);
        logic [1:0]  exc = ref_exc(rd_, wr_, f3, addr);
        bit          is_mem = rd_ || wr_;
        logic [31:0] exp_data = rd_ ? ref_load(f3, addr, rdata) : 32'd0;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_mem_read = rd_; in_mem_write = wr_; in_funct3 = f3;
        in_alu_result = addr; in_rs2_data = rs2; in_pc_plus4 = pc4; in_imm = imm;
        in_reg_src = rs; in_rd = rdst; in_reg_write = rw;
        tick();
        in_valid = 1'b0; in_alu_result = $urandom; in_rs2_data = $urandom;
        in_pc_plus4 = $urandom; in_imm = $urandom; in_funct3 = 3'($urandom);
        if (exc != 2'd0 || !is_mem) begin
            check("no_req", 32'(dmem_req_valid), 32'd0);
            check("out_valid", 32'(out_valid), 32'd1);
            check("mem_exc", 32'(mem_exc), (exc != 2'd0) ? 32'd1 : 32'd0);
            if (exc != 2'd0) check("exc_cause", 32'(exc_cause), 32'(exc));
            check("reg_write", 32'(out_reg_write), (exc != 2'd0) ? 32'd0 : 32'(rw));
            check("mem2reg_zero", out_mem2reg_data, 32'd0);
        end else begin
            check("req_valid", 32'(dmem_req_valid), 32'd1);
            check("req_addr", dmem_addr, addr & ~32'd3);
            check("req_we", 32'(dmem_we), 32'(wr_));
            check("req_be", 32'(dmem_be), wr_ ? ref_be(f3, addr) : 32'd0);
            if (wr_) check("req_wdata", dmem_wdata, ref_wdata(f3, rs2));
            check("busy", 32'(in_ready), 32'd0);
            for (int k = 0; k < req_wait; k++) begin
                dmem_resp_valid = stray; dmem_rdata = $urandom;
                tick();
                check("req_hold_valid", 32'(dmem_req_valid), 32'd1);
                check("req_hold_addr", dmem_addr, addr & ~32'd3);
                if (wr_) check("req_hold_wdata", dmem_wdata, ref_wdata(f3, rs2));
                check("req_no_out", 32'(out_valid), 32'd0);
            end
            dmem_resp_valid = 1'b0; dmem_req_ready = 1'b1;
            tick();
            dmem_req_ready = 1'b0;
            check("req_dropped", 32'(dmem_req_valid), 32'd0);
            for (int k = 0; k < resp_wait; k++) begin
                tick();
                check("resp_wait_no_out", 32'(out_valid), 32'd0);
            end
            dmem_resp_valid = 1'b1; dmem_rdata = rdata;
            tick();
            dmem_resp_valid = 1'b0; dmem_rdata = $urandom;
            check("out_valid", 32'(out_valid), 32'd1);
            check("mem_exc", 32'(mem_exc), 32'd0);
            check("mem2reg", out_mem2reg_data, exp_data);
            check("reg_write", 32'(out_reg_write), 32'(rw));
        end
        check("alu_result", out_alu_result, addr);
        check("pc_plus4", out_pc_plus4, pc4);
        check("imm", out_imm, imm);
        check("reg_src", 32'(out_reg_src), 32'(rs));
        check("rd", 32'(out_rd), 32'(rdst));
        tick();
        check("pulse_end", 32'(out_valid), 32'd0);
        check("exc_pulse_end", 32'(mem_exc), 32'd0);
        check("hold_alu_result", out_alu_result, addr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_exc", 32'(mem_exc), 32'd0);
        check("rst_alu_result", out_alu_result, 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // ALU op pass-through
        run_op(0, 0, 3'd0, 32'h1234_5678, 32'h0, 32'h0000_1004, 32'h0000_0042,
               32'h0, FROM_ALU, 5'd3, 1, 0, 0, 0);
        // LB / LBU at byte 3
        run_op(1, 0, 3'd0, 32'h0000_0103, 32'h0, 32'h0000_2004, 32'h0,
               32'h80FF_0000, FROM_MEM, 5'd4, 1, 0, 0, 0);
        check("lb_value", out_mem2reg_data, 32'hFFFF_FF80);
        run_op(1, 0, 3'd4, 32'h0000_0103, 32'h0, 32'h0000_2008, 32'h0,
               32'h80FF_0000, FROM_MEM, 5'd5, 1, 0, 1, 0);
        check("lbu_value", out_mem2reg_data, 32'h0000_0080);
        // SH with ready held low three cycles
        run_op(0, 1, 3'd1, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_300C, 32'h0,
               32'hDEAD_DEAD, FROM_ALU, 5'd0, 0, 3, 2, 1);
        // Misaligned LW
        run_op(1, 0, 3'd2, 32'h0000_0301, 32'h0, 32'h0000_4000, 32'h0,
               32'h0, FROM_MEM, 5'd7, 1, 0, 0, 0);
        check("misalign_cause", 32'(exc_cause), 32'd1);

        // Response timeout on a load
        in_valid = 1'b1; in_mem_read = 1'b1; in_mem_write = 1'b0; in_funct3 = 3'd2;
        in_alu_result = 32'h0000_0400; in_reg_write = 1'b1; in_rd = 5'd9;
        tick();
        in_valid = 1'b0; in_mem_read = 1'b0;
        dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        for (int k = 0; k < int'(TO) - 1; k++) begin
            tick();
            check("to_wait", 32'(out_valid), 32'd0);
        end
        tick();
        check("to_out_valid", 32'(out_valid), 32'd1);
        check("to_mem_exc", 32'(mem_exc), 32'd1);
        check("to_cause", 32'(exc_cause), 32'd3);
        check("to_reg_write", 32'(out_reg_write), 32'd0);
        check("to_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Randomized mix
        for (int i = 0; i < 150; i++) begin
            int          kind;
            bit          r, w;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            r = (kind >= 3 && kind <= 6);
            w = (kind >= 7);
            if ($urandom_range(0, 19) == 0) begin r = 1; w = 1; end
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_op(r, w, f3, a, $urandom, $urandom, $urandom, $urandom,
                   2'($urandom), 5'($urandom), 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end

        // Reset while the request is pending
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'd2; in_alu_result = 32'h40;
        tick();
        in_valid = 1'b0; in_mem_read = 1'b0;
        check("pre_rst_req", 32'(dmem_req_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_drop", 32'(dmem_req_valid), 32'd0);
        check("rst_req_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Reset while waiting for the response, then a late response
        in_valid = 1'b1; in_mem_read = 1'b1; in_funct3 = 3'd0; in_alu_result = 32'h81;
        tick();
        in_valid = 1'b0; in_mem_read = 1'b0; dmem_req_ready = 1'b1;
        tick();
        dmem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_resp_req", 32'(dmem_req_valid), 32'd0);
        check("rst_resp_out", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        dmem_resp_valid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        check("late_resp_1", 32'(out_valid), 32'd0);
        tick();
        check("late_resp_2", 32'(out_valid), 32'd0);
        dmem_resp_valid = 1'b0;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Recovery after reset
        run_op(0, 0, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0000_5004, 32'h0000_0007,
               32'h0, FROM_PC4, 5'd1, 1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage that sits directly upstream of write-back.
- Takes one instruction at a time from execute and performs the RV32I load or store over a valid/ready data-memory bus.
- Aligns and extends load data, then registers everything write-back consumes: reg_src, pc_plus4, imm, alu_result, mem2reg_data, rd and reg_write.
- Write-back has no backpressure, so out_valid is a single-cycle pulse.

Parameters:
- RESP_TIMEOUT, 255: maximum cycles waiting for a memory response before a bus error; 0 disables the timeout.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  execute presents an instruction
- in_ready  output  1  stage can accept an instruction
- in_mem_read  input  1  load
- in_mem_write  input  1  store
- in_funct3  input  3  RV32I load/store width code
- in_alu_result  input  32  effective address, or ALU result for non-memory ops
- in_rs2_data  input  32  store data
- in_reg_src  input  2  write-back source select, passed through
- in_pc_plus4  input  32  passed through
- in_imm  input  32  passed through
- in_rd  input  5  destination register
- in_reg_write  input  1  register-file write enable
- dmem_req_valid  output  1  memory request valid
- dmem_req_ready  input  1  memory accepts the request
- dmem_addr  output  32  word address, bits [1:0] = 0
- dmem_we  output  1  write request
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-replicated write data
- dmem_resp_valid  input  1  memory response
- dmem_rdata  input  32  read word
- out_valid  output  1  one-cycle result pulse to write-back
- out_reg_src  output  2  registered pass-through
- out_pc_plus4  output  32  registered pass-through
- out_imm  output  32  registered pass-through
- out_alu_result  output  32  registered pass-through
- out_mem2reg_data  output  32  extended load data
- out_rd  output  5  registered pass-through
- out_reg_write  output  1  register-file write enable
- mem_exc  output  1  one-cycle exception pulse, coincident with out_valid
- exc_cause  output  2  01 misaligned, 10 illegal, 11 bus timeout

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset values: state IDLE; every registered output, dmem_req_valid and mem_exc are 0. in_ready = (state == IDLE).
- States: IDLE, REQ, RESP.
- IDLE, accepting: on in_valid & in_ready, the stage captures all inputs.
- IDLE, non-memory op: out_valid on the next cycle (latency 1); out_mem2reg_data = 0.
- IDLE, exception: exceptions are checked in this priority order:
  - both read and write set -> cause 10
  - funct3 not in {000, 001, 010, 100, 101} for loads, or not in {000, 001, 010} for stores -> cause 10
  - halfword with addr[0] = 1, or word with addr[1:0] != 0 -> cause 01

  On an exception there is no bus request; out_valid and mem_exc are asserted next cycle with out_reg_write forced to 0.
- IDLE, valid memory op: go to REQ.
- REQ: dmem_req_valid = 1. Address, we, be and wdata are held stable until dmem_req_ready; on that handshake go to RESP. A load has dmem_be = 4'b0000.
- Store data:
  - SB: byte replicated to all four lanes, be = 0001 << addr[1:0].
  - SH: halfword replicated to both halves, be = 0011 << {addr[1], 0}.
  - SW: be = 1111.
- RESP: dmem_resp_valid is sampled only in RESP, at the earliest the cycle after the request handshake. On response, out_valid fires next cycle and the state returns to IDLE.
- Load extraction: the byte or halfword is selected by addr[1:0]. LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word. For stores, rdata is ignored and out_mem2reg_data = 0.
- Timeout: a counter clears on entry to RESP. When it reaches RESP_TIMEOUT, the stage pulses out_valid and mem_exc with cause 11, forces out_reg_write to 0, and returns to IDLE. Stray responses in IDLE or REQ are ignored.
- Throughput: one memory op per at least 3 cycles; one non-memory op per cycle.
- Output hold: out_* fields hold their last value while out_valid = 0.
- Reset mid-operation: dmem_req_valid drops immediately and the transaction is abandoned. No out_valid is produced for the aborted op.

Decomposition:
- Shared defines header holds: funct3 load/store codes, state encodings, exc_cause codes, and the existing FROM_* reg_src codes.
- One sub-module is natural: load_align, a combinational block (rdata, addr[1:0], funct3 -> extended data), reused by any later cache path.

Test Plan:
- ALU op, alu_result = 0x12345678, reg_src = FROM_ALU -> next cycle out_valid = 1, out_alu_result = 0x12345678, out_mem2reg_data = 0, no dmem_req_valid.
- LB at addr 0x103, rdata = 0x80FF_0000 -> dmem_addr = 0x100, out_mem2reg_data = 0xFFFF_FF80; LBU with the same data -> 0x0000_0080.
- SH at 0x202, rs2 = 0x0000_BEEF, dmem_req_ready held low 3 cycles -> request stable, dmem_be = 1100, dmem_wdata = 0xBEEF_BEEF, dmem_addr = 0x200.
- LW at 0x301 -> no request; out_valid, mem_exc, exc_cause = 01, out_reg_write = 0.
- RESP_TIMEOUT = 4, load with no response -> mem_exc with cause 11 after 4 cycles in RESP, then in_ready = 1.
- rst_n low during RESP -> dmem_req_valid and out_valid are 0; a late dmem_resp_valid after release produces no out_valid.
